// File: rtl/config_chain_shifter_if.sv
`timescale 1ns/1ps
// Word-input handshake between the frame/bitstream controller and the
// configuration chain shifter.
interface config_chain_shifter_if #(
  parameter int WORD_W = 32
);
  logic [WORD_W-1:0] s_data;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;

  modport master (output s_data, output s_valid, output s_last, input s_ready);
  modport slave  (input s_data, input s_valid, input s_last, output s_ready);
endinterface

// File: rtl/config_chain_shifter.sv
`timescale 1ns/1ps
// Writer for a two-phase latch configuration chain: serialises words MSB-first
// under non-overlapping PH1/PH2 strobes and returns the pre-shift chain tail.
module config_chain_shifter #(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 64,
  parameter int PHASE_CYC = 1,
  parameter int GAP_CYC   = 1
) (
  input  logic                  CLK,
  input  logic                  resetn,
  config_chain_shifter_if.slave s_if,
  output logic                  CONFin_o,
  output logic                  PH1,
  output logic                  PH2,
  input  logic                  CONFout_i,
  output logic [WORD_W-1:0]     rb_data,
  output logic                  rb_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  len_err
);

  localparam int IDX_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int MAX_C  = (PHASE_CYC > GAP_CYC) ? PHASE_CYC : GAP_CYC;
  localparam int CNT_W  = $clog2(MAX_C + 1);
  localparam int FB_W   = $clog2(CHAIN_LEN + 2 * WORD_W + 1);

  localparam logic [CNT_W-1:0] PH_LAST  = CNT_W'(PHASE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);
  localparam logic [FB_W-1:0]  FB_WORD  = FB_W'(WORD_W);
  localparam logic [FB_W-1:0]  FB_CHAIN = FB_W'(CHAIN_LEN);
  localparam logic [FB_W-1:0]  FB_SAT   = FB_W'(CHAIN_LEN + WORD_W);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    P1,
    G1,
    P2,
    G2
  } state_t;

  state_t            state_q;
  logic [IDX_W-1:0]  bitIdx_q;
  logic [CNT_W-1:0]  phaseCnt_q;
  logic [WORD_W-1:0] word_q;
  logic              last_q;
  logic [WORD_W-1:0] rbShift_q;
  logic [FB_W-1:0]   frameBits_q;
  logic [FB_W-1:0]   frameBits_d;

  logic              confIn_q;
  logic              ph1_q;
  logic              ph2_q;
  logic [WORD_W-1:0] rbData_q;
  logic              rbValid_q;
  logic              done_q;
  logic              lenErr_q;

  assign frameBits_d = frameBits_q + FB_WORD;

  // word_q holds the bits not yet presented; its MSB is always the next bit.
  // Readback shifts in at the LSB so the first sampled tail bit ends up as MSB.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      bitIdx_q    <= '0;
      phaseCnt_q  <= '0;
      word_q      <= '0;
      last_q      <= 1'b0;
      rbShift_q   <= '0;
      frameBits_q <= '0;
      confIn_q    <= 1'b0;
      ph1_q       <= 1'b0;
      ph2_q       <= 1'b0;
      rbData_q    <= '0;
      rbValid_q   <= 1'b0;
      done_q      <= 1'b0;
      lenErr_q    <= 1'b0;
    end else begin
      rbValid_q <= 1'b0;
      done_q    <= 1'b0;
      lenErr_q  <= 1'b0;

      case (state_q)
        IDLE: begin
          if (s_if.s_valid) begin
            word_q   <= s_if.s_data << 1;
            confIn_q <= s_if.s_data[WORD_W-1];
            last_q   <= s_if.s_last;
            bitIdx_q <= '0;
            state_q  <= SETUP;
          end
        end

        SETUP: begin
          rbShift_q  <= (rbShift_q << 1) | WORD_W'(CONFout_i);
          phaseCnt_q <= '0;
          ph1_q      <= 1'b1;
          state_q    <= P1;
        end

        P1: begin
          if (phaseCnt_q == PH_LAST) begin
            ph1_q      <= 1'b0;
            phaseCnt_q <= '0;
            state_q    <= G1;
          end else begin
            phaseCnt_q <= phaseCnt_q + 1'b1;
          end
        end

        G1: begin
          if (phaseCnt_q == GAP_LAST) begin
            ph2_q      <= 1'b1;
            phaseCnt_q <= '0;
            state_q    <= P2;
          end else begin
            phaseCnt_q <= phaseCnt_q + 1'b1;
          end
        end

        P2: begin
          if (phaseCnt_q == PH_LAST) begin
            ph2_q      <= 1'b0;
            phaseCnt_q <= '0;
            state_q    <= G2;
          end else begin
            phaseCnt_q <= phaseCnt_q + 1'b1;
          end
        end

        // Frame counter saturates just above CHAIN_LEN so an overlong frame
        // keeps flagging without ever wrapping back to a legal length.
        G2: begin
          if (phaseCnt_q == GAP_LAST) begin
            phaseCnt_q <= '0;
            if (bitIdx_q != IDX_LAST) begin
              bitIdx_q <= bitIdx_q + 1'b1;
              confIn_q <= word_q[WORD_W-1];
              word_q   <= word_q << 1;
              state_q  <= SETUP;
            end else begin
              rbData_q  <= rbShift_q;
              rbValid_q <= 1'b1;
              if (last_q) begin
                done_q      <= 1'b1;
                lenErr_q    <= (frameBits_d != FB_CHAIN);
                frameBits_q <= '0;
              end else begin
                lenErr_q    <= (frameBits_d > FB_CHAIN);
                frameBits_q <= (frameBits_d > FB_SAT) ? FB_SAT : frameBits_d;
              end
              state_q <= IDLE;
            end
          end else begin
            phaseCnt_q <= phaseCnt_q + 1'b1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_if.s_ready = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign CONFin_o     = confIn_q;
  assign PH1          = ph1_q;
  assign PH2          = ph2_q;
  assign rb_data      = rbData_q;
  assign rb_valid     = rbValid_q;
  assign done         = done_q;
  assign len_err      = lenErr_q;

endmodule

// File: tb/tb_config_chain_shifter.sv
`timescale 1ns/1ps
// Directed bench for config_chain_shifter: a default-timing instance driving a
// master/slave latch-chain model, plus a slow-strobe instance for timing shape.
module tb_config_chain_shifter;

  localparam int WORD_W    = 32;
  localparam int CHAIN_LEN = 64;
  localparam int PH_A      = 1;
  localparam int GAP_A     = 1;
  localparam int PH_B      = 3;
  localparam int GAP_B     = 2;
  localparam int NV        = 9;

  typedef struct {
    logic [WORD_W-1:0] data;
    logic              last;
    logic [WORD_W-1:0] expRb;
    logic              expDone;
    logic              expErr;
  } vec_t;

  logic CLK    = 1'b0;
  logic resetn = 1'b1;
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  config_chain_shifter_if #(.WORD_W(WORD_W)) ifA ();
  config_chain_shifter_if #(.WORD_W(WORD_W)) ifB ();

  logic              confInA, ph1A, ph2A, confOutA, rbValidA, busyA, doneA, lenErrA;
  logic [WORD_W-1:0] rbDataA;
  logic              confInB, ph1B, ph2B, confOutB, rbValidB, busyB, doneB, lenErrB;
  logic [WORD_W-1:0] rbDataB;

  assign confOutB = 1'b0;

  config_chain_shifter #(
    .WORD_W(WORD_W), .CHAIN_LEN(CHAIN_LEN), .PHASE_CYC(PH_A), .GAP_CYC(GAP_A)
  ) dutA (
    .CLK(CLK), .resetn(resetn), .s_if(ifA),
    .CONFin_o(confInA), .PH1(ph1A), .PH2(ph2A), .CONFout_i(confOutA),
    .rb_data(rbDataA), .rb_valid(rbValidA), .busy(busyA), .done(doneA), .len_err(lenErrA)
  );

  config_chain_shifter #(
    .WORD_W(WORD_W), .CHAIN_LEN(CHAIN_LEN), .PHASE_CYC(PH_B), .GAP_CYC(GAP_B)
  ) dutB (
    .CLK(CLK), .resetn(resetn), .s_if(ifB),
    .CONFin_o(confInB), .PH1(ph1B), .PH2(ph2B), .CONFout_i(confOutB),
    .rb_data(rbDataB), .rb_valid(rbValidB), .busy(busyB), .done(doneB), .len_err(lenErrB)
  );

  // Chain model: CHAIN_LEN bit positions, each a PH1 master and PH2 slave latch.
  logic [CHAIN_LEN-1:0] masterM = '0;
  logic [CHAIN_LEN-1:0] slaveM  = '0;
  always @(posedge ph1A) masterM <= {slaveM[CHAIN_LEN-2:0], confInA};
  always @(posedge ph2A) slaveM <= masterM;
  assign confOutA = slaveM[CHAIN_LEN-1];

  int                ph1CntA = 0;
  int                ph2CntA = 0;
  int                stabErrA = 0;
  logic [WORD_W-1:0] confCap = '0;
  logic              confAtRise = 1'b0;

  always @(posedge ph1A) begin
    ph1CntA    <= ph1CntA + 1;
    confCap    <= {confCap[WORD_W-2:0], confInA};
    confAtRise <= confInA;
  end
  always @(posedge ph2A) ph2CntA <= ph2CntA + 1;
  always @(negedge ph1A) if (resetn && confInA !== confAtRise) stabErrA <= stabErrA + 1;

  int runP1A = 0, runP2A = 0, runLowA = 1000;
  int overlapErrA = 0, widthErrA = 0, gapErrA = 0;
  always @(negedge CLK) begin
    if (ph1A && ph2A) overlapErrA <= overlapErrA + 1;
    runP1A  <= ph1A ? runP1A + 1 : 0;
    runP2A  <= ph2A ? runP2A + 1 : 0;
    runLowA <= (ph1A || ph2A) ? 0 : runLowA + 1;
    if ((!ph1A && runP1A != 0 && runP1A != PH_A) || (!ph2A && runP2A != 0 && runP2A != PH_A))
      widthErrA <= widthErrA + 1;
    if (((ph1A && runP1A == 0) || (ph2A && runP2A == 0)) && runLowA < GAP_A)
      gapErrA <= gapErrA + 1;
  end

  int runP1B = 0, runP2B = 0, runLowB = 1000;
  int overlapErrB = 0, widthErrB = 0, gapErrB = 0;
  int riseCntB = 0, firstRiseB = 0, secondRiseB = 0;
  always @(negedge CLK) begin
    if (ph1B && ph2B) overlapErrB <= overlapErrB + 1;
    runP1B  <= ph1B ? runP1B + 1 : 0;
    runP2B  <= ph2B ? runP2B + 1 : 0;
    runLowB <= (ph1B || ph2B) ? 0 : runLowB + 1;
    if ((!ph1B && runP1B != 0 && runP1B != PH_B) || (!ph2B && runP2B != 0 && runP2B != PH_B))
      widthErrB <= widthErrB + 1;
    if (((ph1B && runP1B == 0) || (ph2B && runP2B == 0)) && runLowB < GAP_B)
      gapErrB <= gapErrB + 1;
    if (ph1B && runP1B == 0) begin
      riseCntB <= riseCntB + 1;
      if (riseCntB == 0) firstRiseB <= cyc;
      if (riseCntB == 1) secondRiseB <= cyc;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [WORD_W-1:0] data, input logic last, output int acceptAt);
    ifA.s_data  = data;
    ifA.s_last  = last;
    ifA.s_valid = 1'b1;
    @(posedge CLK);
    #1;
    acceptAt    = cyc;
    ifA.s_valid = 1'b0;
    ifA.s_last  = 1'b0;
  endtask

  task automatic waitReadbackA(output int lat);
    lat = 0;
    while (lat < 1000 && rbValidA !== 1'b1) begin
      @(posedge CLK);
      #1;
      lat++;
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t              vecs[NV];
    int                lat, acc, prevAcc, k, startP1, startP2;
    logic [WORD_W-1:0] prevData;

    vecs[0] = '{32'h1234_5678, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
    vecs[1] = '{32'hDEAD_BEEF, 1'b1, 32'hA5A5_0001, 1'b1, 1'b0};
    vecs[2] = '{32'hFFFF_FFFF, 1'b0, 32'h1234_5678, 1'b0, 1'b0};
    vecs[3] = '{32'h0000_0000, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0};
    vecs[4] = '{32'hC3C3_C3C3, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1};
    vecs[5] = '{32'h0F0F_0F0F, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
    vecs[6] = '{32'h1111_1111, 1'b0, 32'hC3C3_C3C3, 1'b0, 1'b0};
    vecs[7] = '{32'h2222_2222, 1'b0, 32'h0F0F_0F0F, 1'b0, 1'b1};
    vecs[8] = '{32'h3333_3333, 1'b1, 32'h1111_1111, 1'b1, 1'b1};

    ifA.s_data = '0; ifA.s_valid = 1'b0; ifA.s_last = 1'b0;
    ifB.s_data = '0; ifB.s_valid = 1'b0; ifB.s_last = 1'b0;

    #1 resetn = 1'b0;
    #1;
    checkOutput("rst_strobes", 64'({ph1A, ph2A, confInA}), 64'd0);
    checkOutput("rst_flags", 64'({busyA, rbValidA, doneA, lenErrA}), 64'd0);
    checkOutput("rst_rb_data", 64'(rbDataA), 64'd0);
    checkOutput("rst_s_ready", 64'(ifA.s_ready), 64'd1);
    checkOutput("rst_dut_b", 64'({busyB, ph1B, ph2B, ifB.s_ready}), 64'b0001);
    #20 resetn = 1'b1;

    @(posedge CLK);
    #1;
    repeat (100) @(posedge CLK);
    #1;
    checkOutput("idle_no_strobes", 64'(ph1CntA + ph2CntA + riseCntB), 64'd0);
    checkOutput("idle_ready", 64'({ifA.s_ready, busyA, ph1A, ph2A}), 64'b1000);

    startP1 = ph1CntA;
    startP2 = ph2CntA;
    applyStimulus(32'hA5A5_0001, 1'b0, acc);
    waitReadbackA(lat);
    checkOutput("word0_latency", 64'(lat), 64'd160);
    checkOutput("word0_ph1_count", 64'(ph1CntA - startP1), 64'd32);
    checkOutput("word0_ph2_count", 64'(ph2CntA - startP2), 64'd32);
    checkOutput("word0_confin_seq", 64'(confCap), 64'hA5A5_0001);
    checkOutput("word0_rb_data", 64'(rbDataA), 64'd0);
    checkOutput("word0_flags", 64'({doneA, lenErrA}), 64'd0);
    checkOutput("word0_chain", 64'(slaveM), {32'h0, 32'hA5A5_0001});
    prevData = 32'hA5A5_0001;

    // Restart the frame count so the table begins a fresh frame.
    #1 resetn = 1'b0;
    #2 resetn = 1'b1;
    @(posedge CLK);
    #1;

    prevAcc = 0;
    for (int i = 0; i < NV; i++) begin
      checkOutput("ready_before_word", 64'(ifA.s_ready), 64'd1);
      startP1 = ph1CntA;
      startP2 = ph2CntA;
      applyStimulus(vecs[i].data, vecs[i].last, acc);
      checkOutput("pulses_cleared", 64'({rbValidA, doneA, lenErrA}), 64'd0);
      checkOutput("busy_while_shifting", 64'({busyA, ifA.s_ready}), 64'b10);
      if (i > 0) checkOutput("back_to_back_period", 64'(acc - prevAcc), 64'd161);
      waitReadbackA(lat);
      checkOutput("rb_latency", 64'(lat), 64'd160);
      checkOutput("rb_data", 64'(rbDataA), 64'(vecs[i].expRb));
      checkOutput("done", 64'(doneA), 64'(vecs[i].expDone));
      checkOutput("len_err", 64'(lenErrA), 64'(vecs[i].expErr));
      checkOutput("ph1_count", 64'(ph1CntA - startP1), 64'd32);
      checkOutput("ph2_count", 64'(ph2CntA - startP2), 64'd32);
      checkOutput("chain_contents", 64'(slaveM), {prevData, vecs[i].data});
      prevData = vecs[i].data;
      prevAcc  = acc;
    end
    @(posedge CLK);
    #1;
    checkOutput("done_single_cycle", 64'({rbValidA, doneA, lenErrA}), 64'd0);

    applyStimulus(32'h5A5A_F00D, 1'b1, acc);
    k = 0;
    while (ph1A !== 1'b1 && k < 50) begin
      @(posedge CLK);
      #1;
      k++;
    end
    checkOutput("ph1_reached", 64'(ph1A), 64'd1);
    #1 resetn = 1'b0;
    #1;
    checkOutput("rst_kills_ph1", 64'({ph1A, ph2A, confInA}), 64'd0);
    checkOutput("rst_mid_idle", 64'({busyA, ifA.s_ready}), 64'b01);
    #1 resetn = 1'b1;
    @(posedge CLK);
    #1;
    startP1 = ph1CntA;
    startP2 = ph2CntA;
    applyStimulus(32'h0000_FFFF, 1'b1, acc);
    waitReadbackA(lat);
    checkOutput("post_rst_latency", 64'(lat), 64'd160);
    checkOutput("post_rst_ph1_count", 64'(ph1CntA - startP1), 64'd32);
    checkOutput("post_rst_ph2_count", 64'(ph2CntA - startP2), 64'd32);
    checkOutput("post_rst_flags", 64'({doneA, lenErrA}), 64'b11);
    checkOutput("post_rst_rb_data", 64'(rbDataA), 64'h2222_2222);

    @(posedge CLK);
    #1;
    ifB.s_data  = 32'h8000_0001;
    ifB.s_last  = 1'b1;
    ifB.s_valid = 1'b1;
    @(posedge CLK);
    #1;
    ifB.s_valid = 1'b0;
    ifB.s_last  = 1'b0;
    lat = 0;
    while (lat < 2000 && rbValidB !== 1'b1) begin
      @(posedge CLK);
      #1;
      lat++;
    end
    checkOutput("b_word_latency", 64'(lat), 64'd352);
    checkOutput("b_bit_period", 64'(secondRiseB - firstRiseB), 64'd11);
    checkOutput("b_ph1_count", 64'(riseCntB), 64'd32);
    checkOutput("b_flags", 64'({doneB, lenErrB}), 64'b11);
    checkOutput("b_rb_data", 64'(rbDataB), 64'd0);

    checkOutput("a_overlap", 64'(overlapErrA), 64'd0);
    checkOutput("a_strobe_width", 64'(widthErrA), 64'd0);
    checkOutput("a_strobe_gap", 64'(gapErrA), 64'd0);
    checkOutput("a_confin_stable", 64'(stabErrA), 64'd0);
    checkOutput("b_overlap", 64'(overlapErrB), 64'd0);
    checkOutput("b_strobe_width", 64'(widthErrB), 64'd0);
    checkOutput("b_strobe_gap", 64'(gapErrB), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/config_chain_shifter.md
Name: config_chain_shifter

Overview:
- Writer side of the latch-based configuration chain used by the fabric's LUT/MUX primitives. Each chain stage is a transparent latch (D/E/Q), and the stages are chained CONFin -> CONFout.
- The block accepts configuration words over a valid/ready port and serialises them MSB-first onto the chain head. Each bit is shifted with two non-overlapping latch-enable strobes, PH1 and PH2.
- It captures the chain tail (CONFout) on every shift and returns it as readback words. It sits between the frame/bitstream controller and one configuration chain.

Parameters:
- WORD_W, 32, data word width in bits.
- CHAIN_LEN, 64, bits per frame. Must be a nonzero multiple of WORD_W.
- PHASE_CYC, 1, CLK cycles each strobe is held high (>=1).
- GAP_CYC, 1, CLK cycles both strobes are held low after each strobe (>=1).

Ports:
- CLK, input, 1, sole clock; all state is on the rising edge.
- resetn, input, 1, asynchronous active-low reset.
- s_data, input, WORD_W, configuration word; bit WORD_W-1 is shifted first.
- s_valid, input, 1, s_data is valid.
- s_last, input, 1, word is the final word of the frame; qualified by s_valid.
- s_ready, output, 1, block accepts a word this cycle.
- CONFin_o, output, 1, serial data to the chain head (first latch D).
- PH1, output, 1, enable for odd-position latches (drives the first latch E).
- PH2, output, 1, enable for even-position latches (drives the second latch E/MODE).
- CONFout_i, input, 1, chain tail returned from the last latch.
- rb_data, output, WORD_W, readback word.
- rb_valid, output, 1, one-cycle pulse; rb_data is valid.
- busy, output, 1, high in every state except IDLE.
- done, output, 1, one-cycle pulse at end of a frame.
- len_err, output, 1, one-cycle pulse coincident with done when the frame length is wrong.

Behaviour:
- Reset (async, resetn=0) forces all of the following, immediately and regardless of CLK:
  - state IDLE, all counters 0;
  - PH1=0, PH2=0, CONFin_o=0, rb_data=0, rb_valid=0, done=0, len_err=0, busy=0;
  - s_ready=1 (s_ready is decoded from state==IDLE).
  - Reset mid-shift kills any active strobe at once. Chain contents are then undefined; the controller must reload the whole frame.
- PH1, PH2, CONFin_o, rb_*, done and len_err are driven directly from flops (glitch-free).
- State machine:
  - IDLE: s_ready=1. On s_valid, latch s_data and s_last, clear bit_idx, go to SETUP.
  - SETUP (1 cycle): drive CONFin_o = word[WORD_W-1-bit_idx]. Sample CONFout_i into rb shift register position WORD_W-1-bit_idx. Go to P1.
  - P1 (PHASE_CYC cycles): PH1=1. Go to G1.
  - G1 (GAP_CYC cycles): both strobes low. Go to P2.
  - P2 (PHASE_CYC cycles): PH2=1. Go to G2.
  - G2 (GAP_CYC cycles): both strobes low.
    - If bit_idx < WORD_W-1: increment bit_idx, go to SETUP.
    - Otherwise (last bit of the word):
      - pulse rb_valid with the assembled word;
      - add WORD_W to frame_bits;
      - if the word had s_last: pulse done, pulse len_err if frame_bits != CHAIN_LEN, clear frame_bits;
      - go to IDLE.
- Invariants:
  - PH1 and PH2 are never high in the same cycle.
  - Each strobe is preceded and followed by at least GAP_CYC cycles with both low.
  - CONFin_o changes only in SETUP, so it is stable for the whole of P1.
- Timing:
  - Per bit: 1 + 2*PHASE_CYC + 2*GAP_CYC cycles; 5 cycles with defaults.
  - Per word: WORD_W times the per-bit count, plus 1 IDLE accept cycle.
  - Back-to-back words therefore cost 161 cycles with defaults.
- Frame length:
  - If frame_bits would exceed CHAIN_LEN before an s_last word: pulse len_err at the end of that word, then keep counting.
  - The bench then sees len_err again at done. The frame is still shifted; the block does not truncate.
- Readback: rb_data carries the pre-shift tail values. After N*CHAIN_LEN bits, readback equals the data written CHAIN_LEN bits earlier.
- No backpressure on readback: rb_valid is a one-cycle pulse and is never stalled.

Test Plan:
- Reset then idle -> s_ready=1, PH1=PH2=0, busy=0, with no strobe activity over 100 cycles.
- Write word 0xA5A5_0001 (s_last=0) into a bench latch-chain model -> 32 PH1 and 32 PH2 pulses, each PH1 2 cycles after a SETUP. CONFin_o follows 1,0,1,0,0,1,0,1,... Strobes never overlap. rb_valid appears 160 cycles after accept.
- Frame 0x1234_5678 then 0xDEAD_BEEF (s_last=1), CHAIN_LEN=64 -> done=1, len_err=0. Model chain holds the 64 bits in order.
- Repeat with frame 0xFFFF_FFFF, 0x0000_0000 -> the two rb_valid words are 0x1234_5678 and 0xDEAD_BEEF.
- Single word with s_last=1 (32 bits, CHAIN_LEN=64) -> done=1 and len_err=1 in the same cycle.
- Assert resetn=0 during a P1 cycle -> PH1 falls the same cycle, before the next CLK edge. After release, s_ready=1 and the next word shifts normally.
- PHASE_CYC=3, GAP_CYC=2 -> per-bit period of 11 cycles. PH1 and PH2 are high exactly 3 cycles each with a gap of at least 2 cycles. Word takes 352+1 cycles.
